// File: rtl/mult8_seq_pkg.sv
// Shared constants, state encoding and step helpers for the sequential 8x8 multiplier.
package mult8_seq_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned HALF  = W / 2;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned PPW   = 2 * HALF;
  localparam int unsigned NSTEP = 4;

  typedef enum logic [2:0] {
    IDLE,
    LL,
    LH,
    HL,
    HH,
    DONE
  } state_t;

  // Left shift applied to each nibble partial product, indexed by step (LL, LH, HL, HH).
  localparam int unsigned STEP_SHIFT [NSTEP] = '{0, HALF, HALF, W};

  function automatic state_t step_state(input logic [1:0] idx);
    case (idx)
      2'd0:    return LL;
      2'd1:    return LH;
      2'd2:    return HL;
      default: return HH;
    endcase
  endfunction

  // Bit 1 selects the A nibble, bit 0 the B nibble.
  function automatic logic [1:0] step_index(input state_t s);
    case (s)
      LH:      return 2'd1;
      HL:      return 2'd2;
      HH:      return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [NSTEP-1:0] skip_mask(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input bit           en);
    logic a_lo_z, a_hi_z, b_lo_z, b_hi_z;
    a_lo_z = (a[HALF-1:0] == '0);
    a_hi_z = (a[W-1:HALF] == '0);
    b_lo_z = (b[HALF-1:0] == '0);
    b_hi_z = (b[W-1:HALF] == '0);
    if (!en) return '0;
    return {a_hi_z || b_hi_z, a_hi_z || b_lo_z, a_lo_z || b_hi_z, a_lo_z || b_lo_z};
  endfunction

  // First non-skipped step at or after index start; DONE when none remain.
  function automatic state_t next_step(input logic [2:0]       start,
                                       input logic [NSTEP-1:0] skip);
    state_t s;
    s = DONE;
    for (int i = int'(NSTEP) - 1; i >= 0; i--) begin
      if (i >= int'(start) && !skip[i]) s = step_state(2'(i));
    end
    return s;
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_mult4_core.sv
// Combinational 4x4 unsigned multiplier; replaceable by a generated gate-level netlist.
module mult4_core
  import mult8_seq_pkg::*;
(
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  output logic [PPW-1:0]  p
);

  assign p = PPW'(a) * PPW'(b);

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one 4x4 core time-shared over the four nibble products,
// with valid/ready handshakes on operands and product.
module mult8_seq_ctrl
  import mult8_seq_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p,
  output logic          busy
);

  state_t          state, state_next;
  logic [W-1:0]    a_r, b_r;
  logic [PW-1:0]   acc, acc_next;
  logic            load;
  logic [1:0]      step;
  logic [HALF-1:0] nib_a, nib_b;
  logic [PPW-1:0]  core_p;
  logic [PW-1:0]   pp;

  // Nibble selection for the current step
  assign step  = step_index(state);
  assign nib_a = step[1] ? a_r[W-1:HALF] : a_r[HALF-1:0];
  assign nib_b = step[0] ? b_r[W-1:HALF] : b_r[HALF-1:0];

  mult4_core u_core (
    .a (nib_a),
    .b (nib_b),
    .p (core_p)
  );

  assign pp = PW'(core_p) << STEP_SHIFT[step];

  // Next-state and accumulator update
  always_comb begin
    state_next = state;
    acc_next   = acc;
    load       = 1'b0;
    case (state)
      IDLE: begin
        // Live operands are only looked at when in_valid is high, so X on idle inputs stays out.
        if (in_valid && in_ready) begin
          load       = 1'b1;
          acc_next   = '0;
          state_next = next_step(3'd0, skip_mask(a, b, SKIP_ZERO));
        end
      end
      LL, LH, HL, HH: begin
        acc_next   = acc + pp;
        state_next = next_step(3'(step) + 3'd1, skip_mask(a_r, b_r, SKIP_ZERO));
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      p         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
      if (load) begin
        a_r <= a;
        b_r <= b;
      end
      // p only changes on entry to DONE and holds through the handshake and beyond.
      if (state_next == DONE && state != DONE) p <= acc_next;
    end
  end

endmodule
